// File: rtl/im_loader.sv
// im_loader: framed UART byte stream (sync, len, big-endian words, xor csum) to instruction-memory word writes, holding the CPU in reset while loading
module im_loader #(
  parameter int          ADDR_W      = 10,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_ok,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LHI = 3'd1, S_LLO = 3'd2, S_DATA = 3'd3, S_CSUM = 3'd4, S_ERR = 3'd5;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [2:0]    st;
  logic [7:0]    len_hi;
  logic [ADDR_W:0] n;
  logic [1:0]    bidx;
  logic [23:0]   wsh;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;
  logic [15:0]   len;
  logic          len_bad, active, last_word, timeout;
  assign len       = {len_hi, rx_data};
  assign len_bad   = len == 16'd0 || 32'(len) > (32'd1 << ADDR_W);
  assign active    = st == S_LHI || st == S_LLO || st == S_DATA || st == S_CSUM;
  assign last_word = words_loaded + (ADDR_W+1)'(1) == n;
  assign timeout   = !rx_valid && active && tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      len_hi       <= '0;
      n            <= '0;
      bidx         <= '0;
      wsh          <= '0;
      csum         <= '0;
      tcnt         <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_ok      <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      im_we     <= 1'b0;
      load_done <= 1'b0;
      tcnt      <= rx_valid ? '0 : active ? tcnt + TW'(1) : tcnt;
      if (timeout) begin
        st       <= S_ERR;
        load_err <= 1'b1;
      end else if (rx_valid) begin
        case (st)
          S_IDLE, S_ERR:
            if (rx_data == SYNC_BYTE) begin
              st           <= S_LHI;
              load_ok      <= 1'b0;
              load_err     <= 1'b0;
              words_loaded <= '0;
              csum         <= '0;
              bidx         <= '0;
              im_addr      <= '0;
              cpu_hold     <= 1'b1;
            end
          S_LHI: begin
            len_hi <= rx_data;
            st     <= S_LLO;
          end
          S_LLO: begin
            n        <= len[ADDR_W:0];
            st       <= len_bad ? S_ERR : S_DATA;
            load_err <= len_bad;
          end
          S_DATA: begin
            csum <= csum ^ rx_data;
            wsh  <= {wsh[15:0], rx_data};
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              im_we        <= 1'b1;
              im_wdata     <= {wsh, rx_data};
              im_addr      <= words_loaded[ADDR_W-1:0];
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
              if (last_word) st <= S_CSUM;
            end
          end
          S_CSUM:
            if (rx_data == csum) begin
              st        <= S_IDLE;
              load_done <= 1'b1;
              load_ok   <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              st       <= S_ERR;
              load_err <= 1'b1;
            end
          default: st <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized directed checks of im_loader against a frame-level reference model
module tb_im_loader;
  localparam int AW = 10;
  localparam int TO = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          im_we, cpu_hold, load_done, load_ok, load_err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   words_loaded;
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  logic [41:0]   wr_q[$];
  logic [31:0]   words[$];
  always #5 clk = ~clk;
  im_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_ok(load_ok), .load_err(load_err), .words_loaded(words_loaded)
  );
  always @(negedge clk) if (rst_n) begin
    if (im_we) wr_q.push_back({im_addr, im_wdata});
    if (load_done) done_cnt++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] xsum();
    logic [7:0] c = 8'h00;
    foreach (words[i]) c ^= words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    return c;
  endfunction
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic send_hdr(input logic [15:0] len);
    send_byte(8'hA5);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
  endtask
  task automatic send_words(input int nbytes);
    for (int j = 0; j < nbytes; j++) send_byte(words[j/4][8*(3-j%4) +: 8]);
  endtask
  task automatic send_frame(input logic [15:0] len, input logic [7:0] cs);
    send_hdr(len);
    send_words(4 * words.size());
    send_byte(cs);
  endtask
  task automatic check_writes(input string tag);
    chk(tag, 64'(wr_q.size()), 64'(words.size()));
    foreach (wr_q[i]) if (i < words.size()) chk(tag, 64'(wr_q[i]), 64'({AW'(i), words[i]}));
  endtask
  task automatic clear();
    wr_q.delete();
    done_cnt = 0;
  endtask
  task automatic rand_words(input int cnt);
    words.delete();
    for (int i = 0; i < cnt; i++) words.push_back($urandom);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", 64'({im_we, im_addr, im_wdata, cpu_hold, load_done, load_ok, load_err, words_loaded}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear();
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    chk("garbage_hold", 64'(cpu_hold), 64'd0);
    chk("garbage_writes", 64'(wr_q.size()), 64'd0);
    words = '{32'h20080005, 32'h00000000};
    clear();
    send_frame(16'h0002, 8'h2D);
    @(negedge clk);
    check_writes("good_writes");
    chk("good_done", 64'(done_cnt), 64'd1);
    chk("good_ok", 64'(load_ok), 64'd1);
    chk("good_err", 64'(load_err), 64'd0);
    chk("good_hold", 64'(cpu_hold), 64'd0);
    chk("good_words", 64'(words_loaded), 64'd2);
    clear();
    send_frame(16'h0002, 8'h00);
    @(negedge clk);
    check_writes("bad_writes");
    chk("bad_err", 64'(load_err), 64'd1);
    chk("bad_ok", 64'(load_ok), 64'd0);
    chk("bad_hold", 64'(cpu_hold), 64'd1);
    chk("bad_done", 64'(done_cnt), 64'd0);
    rand_words(3);
    clear();
    send_frame(16'h0003, xsum());
    @(negedge clk);
    check_writes("recover_writes");
    chk("recover_ok", 64'(load_ok), 64'd1);
    chk("recover_err", 64'(load_err), 64'd0);
    chk("recover_hold", 64'(cpu_hold), 64'd0);
    words.delete();
    clear();
    send_hdr(16'h0000);
    chk("len0_err", 64'(load_err), 64'd1);
    chk("len0_hold", 64'(cpu_hold), 64'd1);
    send_hdr(16'h0401);
    chk("len1025_err", 64'(load_err), 64'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    @(negedge clk);
    chk("len_bad_writes", 64'(wr_q.size()), 64'd0);
    rand_words(2);
    clear();
    send_hdr(16'h0002);
    send_words(6);
    chk("to_hold", 64'(cpu_hold), 64'd1);
    repeat (TO - 1) @(negedge clk);
    chk("to_before", 64'(load_err), 64'd0);
    @(negedge clk);
    chk("to_at", 64'(load_err), 64'd1);
    repeat (3) @(negedge clk);
    void'(words.pop_back());
    check_writes("to_writes");
    chk("to_words", 64'(words_loaded), 64'd1);
    chk("to_hold_err", 64'(cpu_hold), 64'd1);
    chk("to_done", 64'(done_cnt), 64'd0);
    rand_words(2);
    send_hdr(16'h0002);
    send_words(6);
    chk("mid_words", 64'(words_loaded), 64'd1);
    rst_n = 1'b0;
    #1 chk("mid_reset_outputs", 64'({im_we, im_addr, im_wdata, cpu_hold, load_done, load_ok, load_err, words_loaded}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    @(negedge clk);
    chk("post_reset_idle_writes", 64'(wr_q.size()), 64'd0);
    chk("post_reset_idle_hold", 64'(cpu_hold), 64'd0);
    rand_words(1024);
    clear();
    send_frame(16'h0400, xsum());
    @(negedge clk);
    check_writes("full_writes");
    chk("full_done", 64'(done_cnt), 64'd1);
    chk("full_ok", 64'(load_ok), 64'd1);
    chk("full_words", 64'(words_loaded), 64'd1024);
    chk("full_hold", 64'(cpu_hold), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
